// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single data-memory port between the CPU M stage
// and an external master (loader/debug/DMA). The CPU has fixed priority and
// the external side is guaranteed service after at most STARVE_MAX lost
// cycles. External requests are buffered in a holding register and answered
// with a registered response.
//
// The memory read data (dm_rd) is an input: the DM returns it combinationally.
//
// Optional build macro: DM_ARB_ALIGN_CHECK_EN
//   When defined, misaligned external requests are answered with ext_err
//   without touching memory. A cpu_err output flags misaligned granted CPU
//   accesses, and their store enable is suppressed.
module dm_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic        clk,
  input  logic        reset,
  // CPU M-stage side
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wd,
  input  logic [1:0]  cpu_width,
  input  logic        cpu_sign,
  output logic [31:0] cpu_rd,
  output logic        cpu_stall,
`ifdef DM_ARB_ALIGN_CHECK_EN
  output logic        cpu_err,
`endif
  // external master request channel
  input  logic        ext_valid,
  output logic        ext_ready,
  input  logic        ext_we,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wd,
  input  logic [1:0]  ext_width,
  input  logic        ext_sign,
  // external master response channel
  output logic        ext_rvalid,
  input  logic        ext_rready,
  output logic [31:0] ext_rdata,
  output logic        ext_err,
  // data memory port
  output logic [31:0] dm_a,
  output logic [31:0] dm_wd,
  output logic        dm_we,
  output logic [1:0]  dm_width,
  output logic        dm_sign,
  input  logic [31:0] dm_rd
);

  typedef enum logic [1:0] {IDLE, PEND, RESP} state_t;

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_nxt;

  // holding register for the accepted external request
  logic        h_we;
  logic [31:0] h_addr;
  logic [31:0] h_wd;
  logic [1:0]  h_width;
  logic        h_sign;

  logic accept;
  logic ext_gnt;
  logic cpu_gnt;
  logic ext_bad;
  logic cpu_bad;

  // Word accesses need addr[1:0]==0, halfword accesses need addr[0]==0.
  function automatic logic misaligned(input logic [1:0] width, input logic [1:0] lo);
    return ((width == 2'd0) && (lo != 2'd0)) || ((width == 2'd1) && lo[0]);
  endfunction

  // Requests that complete with an error and never touch memory.
`ifdef DM_ARB_ALIGN_CHECK_EN
  assign ext_bad = (ext_width == 2'd3) || misaligned(ext_width, ext_addr[1:0]);
  assign cpu_bad = misaligned(cpu_width, cpu_addr[1:0]);
  assign cpu_err = cpu_gnt & cpu_bad;
`else
  assign ext_bad = (ext_width == 2'd3);
  assign cpu_bad = 1'b0;
`endif

  assign cpu_rd = dm_rd;

  // Grant decision, DM port mux and next-state logic.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    dm_a       = 32'd0;
    dm_wd      = 32'd0;
    dm_we      = 1'b0;
    dm_width   = 2'd0;
    dm_sign    = 1'b0;

    ext_ready = reset && (state == IDLE);
    accept    = ext_valid && ext_ready;
    ext_gnt   = (state == PEND) && (!cpu_req || (starve_cnt == STARVE_LIM));
    cpu_gnt   = cpu_req && !ext_gnt;
    cpu_stall = cpu_req && !cpu_gnt;

    if (ext_gnt) begin
      dm_a     = h_addr;
      dm_wd    = h_wd;
      dm_we    = h_we && reset;
      dm_width = h_width;
      dm_sign  = h_sign;
    end else if (cpu_gnt) begin
      dm_a     = cpu_addr;
      dm_wd    = cpu_wd;
      dm_we    = cpu_we && !cpu_bad && reset;
      dm_width = cpu_width;
      dm_sign  = cpu_sign;
    end

    case (state)
      IDLE: begin
        if (accept) state_nxt = ext_bad ? RESP : PEND;
      end
      PEND: begin
        if (ext_gnt) begin
          state_nxt  = RESP;
          starve_nxt = '0;
        end else if (cpu_req && (starve_cnt != STARVE_LIM)) begin
          starve_nxt = starve_cnt + 1'b1;
        end
      end
      RESP: begin
        if (ext_rready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state: FSM, starvation counter and response-valid flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      ext_rvalid <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      ext_rvalid <= (state_nxt == RESP);
    end
  end

  // Holding register capture and registered external response data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_we      <= 1'b0;
      h_addr    <= 32'd0;
      h_wd      <= 32'd0;
      h_width   <= 2'd0;
      h_sign    <= 1'b0;
      ext_rdata <= 32'd0;
      ext_err   <= 1'b0;
    end else begin
      if (accept) begin
        h_we    <= ext_we;
        h_addr  <= ext_addr;
        h_wd    <= ext_wd;
        h_width <= ext_width;
        h_sign  <= ext_sign;
        if (ext_bad) begin
          ext_rdata <= 32'd0;
          ext_err   <= 1'b1;
        end
      end
      if (ext_gnt) begin
        ext_rdata <= h_we ? 32'd0 : dm_rd;
        ext_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed testbench for dm_arbiter with a small byte-addressed data memory
// model (combinational read, clocked write, little-endian lanes).
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_sign;
  logic [31:0] cpu_addr, cpu_wd, cpu_rd;
  logic [1:0]  cpu_width;
  logic        cpu_stall;
`ifdef DM_ARB_ALIGN_CHECK_EN
  logic        cpu_err;
`endif
  logic        ext_valid, ext_ready, ext_we, ext_sign;
  logic [31:0] ext_addr, ext_wd;
  logic [1:0]  ext_width;
  logic        ext_rvalid, ext_rready, ext_err;
  logic [31:0] ext_rdata;
  logic [31:0] dm_a, dm_wd, dm_rd;
  logic        dm_we, dm_sign;
  logic [1:0]  dm_width;

  int vecs = 0;
  int errs = 0;
  int we_cnt = 0;

  logic [31:0] mem [0:63];
  logic [31:0] word;
  logic [15:0] hw;
  logic [7:0]  bt;

  always #5 clk = ~clk;

  dm_arbiter #(.STARVE_MAX(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_width(cpu_width), .cpu_sign(cpu_sign), .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
`ifdef DM_ARB_ALIGN_CHECK_EN
    .cpu_err(cpu_err),
`endif
    .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wd(ext_wd), .ext_width(ext_width), .ext_sign(ext_sign),
    .ext_rvalid(ext_rvalid), .ext_rready(ext_rready), .ext_rdata(ext_rdata), .ext_err(ext_err),
    .dm_a(dm_a), .dm_wd(dm_wd), .dm_we(dm_we), .dm_width(dm_width), .dm_sign(dm_sign),
    .dm_rd(dm_rd)
  );

  // Memory model read path.
  always_comb begin
    word = mem[dm_a[7:2]];
    hw   = dm_a[1] ? word[31:16] : word[15:0];
    bt   = 8'd0;
    case (dm_a[1:0])
      2'd0: bt = word[7:0];
      2'd1: bt = word[15:8];
      2'd2: bt = word[23:16];
      default: bt = word[31:24];
    endcase
    case (dm_width)
      2'd0: dm_rd = word;
      2'd1: dm_rd = dm_sign ? {{16{hw[15]}}, hw} : {16'd0, hw};
      default: dm_rd = dm_sign ? {{24{bt[7]}}, bt} : {24'd0, bt};
    endcase
  end

  // Memory model write path and store-pulse counter.
  always @(posedge clk) begin
    if (dm_we === 1'b1) begin
      we_cnt <= we_cnt + 1;
      case (dm_width)
        2'd0: mem[dm_a[7:2]] <= dm_wd;
        2'd1: if (dm_a[1]) mem[dm_a[7:2]][31:16] <= dm_wd[15:0];
              else         mem[dm_a[7:2]][15:0]  <= dm_wd[15:0];
        default: case (dm_a[1:0])
          2'd0: mem[dm_a[7:2]][7:0]   <= dm_wd[7:0];
          2'd1: mem[dm_a[7:2]][15:8]  <= dm_wd[7:0];
          2'd2: mem[dm_a[7:2]][23:16] <= dm_wd[7:0];
          default: mem[dm_a[7:2]][31:24] <= dm_wd[7:0];
        endcase
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ext_issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] w, input logic s);
    ext_valid = 1'b1; ext_we = we; ext_addr = a; ext_wd = d; ext_width = w; ext_sign = s;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wd = 32'h1234; cpu_width = 2'd0; cpu_sign = 1'b0;
    ext_valid = 1'b1; ext_we = 1'b0; ext_addr = 32'h0; ext_wd = 32'h0; ext_width = 2'd0; ext_sign = 1'b0;
    ext_rready = 1'b0;
    #3;
    vecs++; if (ext_ready !== 1'b0) begin errs++; $display("FAIL reset_ready got %b want 0", ext_ready); end
    vecs++; if (dm_we !== 1'b0) begin errs++; $display("FAIL reset_dm_we got %b want 0", dm_we); end
    vecs++; if (cpu_stall !== 1'b0) begin errs++; $display("FAIL reset_stall got %b want 0", cpu_stall); end
    vecs++; if ({ext_rvalid, ext_err, ext_rdata} !== 34'd0) begin errs++;
      $display("FAIL reset_resp got rvalid=%b err=%b rdata=%h want 0/0/0", ext_rvalid, ext_err, ext_rdata); end
    step(); step();
    vecs++; if (we_cnt !== 0) begin errs++; $display("FAIL reset_no_write got %0d want 0", we_cnt); end
    cpu_req = 1'b0; cpu_we = 1'b0; ext_valid = 1'b0;
    @(negedge clk); reset = 1'b1; #1;
    vecs++; if (ext_ready !== 1'b1) begin errs++; $display("FAIL reset_release_ready got %b want 1", ext_ready); end
  endtask

  task automatic test_ext_write();
    int w0;
    ext_issue(1'b1, 32'h10, 32'hDEADBEEF, 2'd0, 1'b0); #1;
    vecs++; if (ext_ready !== 1'b1) begin errs++; $display("FAIL wr_ready got %b want 1", ext_ready); end
    step(); ext_valid = 1'b0; #1;
    w0 = we_cnt;
    vecs++; if ({dm_we, dm_a, dm_wd} !== {1'b1, 32'h10, 32'hDEADBEEF}) begin errs++;
      $display("FAIL wr_dm_port got we=%b a=%h wd=%h want 1/00000010/deadbeef", dm_we, dm_a, dm_wd); end
    vecs++; if ({ext_ready, ext_rvalid} !== 2'b00) begin errs++;
      $display("FAIL wr_pend got ready=%b rvalid=%b want 0/0", ext_ready, ext_rvalid); end
    step();
    vecs++; if ({ext_rvalid, ext_err, ext_rdata} !== {1'b1, 1'b0, 32'd0}) begin errs++;
      $display("FAIL wr_resp got rvalid=%b err=%b rdata=%h want 1/0/0", ext_rvalid, ext_err, ext_rdata); end
    vecs++; if (dm_we !== 1'b0 || we_cnt !== w0 + 1) begin errs++;
      $display("FAIL wr_one_pulse got dm_we=%b pulses=%0d want 0/%0d", dm_we, we_cnt - w0, 1); end
    vecs++; if (mem[4] !== 32'hDEADBEEF) begin errs++; $display("FAIL wr_mem got %h want deadbeef", mem[4]); end
    ext_rready = 1'b1; step(); ext_rready = 1'b0; #1;
    vecs++; if ({ext_rvalid, ext_ready} !== 2'b01) begin errs++;
      $display("FAIL wr_done got rvalid=%b ready=%b want 0/1", ext_rvalid, ext_ready); end
  endtask

  task automatic test_ext_read();
    ext_issue(1'b0, 32'h10, 32'h0, 2'd0, 1'b0);
    step(); ext_valid = 1'b0; #1;
    vecs++; if ({dm_we, dm_a} !== {1'b0, 32'h10}) begin errs++;
      $display("FAIL rd_dm_port got we=%b a=%h want 0/00000010", dm_we, dm_a); end
    step();
    vecs++; if ({ext_rvalid, ext_err, ext_rdata} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin errs++;
      $display("FAIL rd_resp got rvalid=%b err=%b rdata=%h want 1/0/deadbeef", ext_rvalid, ext_err, ext_rdata); end
    ext_rready = 1'b1; step(); ext_rready = 1'b0;
  endtask

  task automatic test_starvation();
    logic [3:0] stalls;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20; cpu_width = 2'd0;
    ext_issue(1'b0, 32'h10, 32'h0, 2'd0, 1'b0); #1;
    vecs++; if (cpu_stall !== 1'b0) begin errs++; $display("FAIL starve_accept_stall got %b want 0", cpu_stall); end
    step(); ext_valid = 1'b0; #1;
    stalls = 4'd0;
    for (int i = 0; i < 4; i++) begin
      stalls[i] = cpu_stall;
      if (i < 3) step();
      else begin @(posedge clk); #1; end
    end
    vecs++; if (stalls !== 4'b0000) begin errs++; $display("FAIL starve_cpu_wins got stalls=%b want 0000", stalls); end
    vecs++; if ({cpu_stall, dm_a, ext_rvalid} !== {1'b1, 32'h10, 1'b0}) begin errs++;
      $display("FAIL starve_ext_gnt got stall=%b a=%h rvalid=%b want 1/00000010/0", cpu_stall, dm_a, ext_rvalid); end
    step();
    vecs++; if ({cpu_stall, ext_rvalid, ext_rdata} !== {1'b0, 1'b1, 32'hDEADBEEF}) begin errs++;
      $display("FAIL starve_after got stall=%b rvalid=%b rdata=%h want 0/1/deadbeef", cpu_stall, ext_rvalid, ext_rdata); end
    ext_rready = 1'b1; step(); ext_rready = 1'b0; cpu_req = 1'b0;
  endtask

  task automatic test_cpu_store();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wd = 32'h80ABCD12; cpu_width = 2'd0; #1;
    vecs++; if ({dm_we, cpu_stall, dm_a} !== {1'b1, 1'b0, 32'h10}) begin errs++;
      $display("FAIL cpu_sw got we=%b stall=%b a=%h want 1/0/00000010", dm_we, cpu_stall, dm_a); end
    step();
    cpu_addr = 32'h20; cpu_wd = 32'h12345678; step();
    cpu_we = 1'b0; #1;
    vecs++; if (cpu_rd !== 32'h12345678) begin errs++; $display("FAIL cpu_lw got %h want 12345678", cpu_rd); end
    cpu_req = 1'b0;
  endtask

  task automatic test_byte_sign();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20; cpu_width = 2'd0;
    ext_issue(1'b0, 32'h13, 32'h0, 2'd2, 1'b1);
    step(); ext_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    vecs++; if ({cpu_stall, dm_a, dm_width, dm_sign} !== {1'b1, 32'h13, 2'd2, 1'b1}) begin errs++;
      $display("FAIL byte_gnt got stall=%b a=%h w=%0d s=%b want 1/00000013/2/1", cpu_stall, dm_a, dm_width, dm_sign); end
    step();
    vecs++; if (ext_rdata !== 32'hFFFFFF80) begin errs++; $display("FAIL byte_sign got %h want ffffff80", ext_rdata); end
    vecs++; if ({cpu_stall, cpu_rd} !== {1'b0, 32'h12345678}) begin errs++;
      $display("FAIL byte_cpu_resume got stall=%b rd=%h want 0/12345678", cpu_stall, cpu_rd); end
    ext_rready = 1'b1; step(); ext_rready = 1'b0; cpu_req = 1'b0;
    ext_issue(1'b0, 32'h12, 32'h0, 2'd1, 1'b0);
    step(); ext_valid = 1'b0; step();
    vecs++; if (ext_rdata !== 32'h000080AB) begin errs++; $display("FAIL half_zero got %h want 000080ab", ext_rdata); end
    ext_rready = 1'b1; step(); ext_rready = 1'b0;
  endtask

  task automatic test_rready_stall();
    int w0;
    ext_issue(1'b0, 32'h10, 32'h0, 2'd0, 1'b0);
    step(); ext_valid = 1'b0; step();
    w0 = we_cnt;
    for (int i = 0; i < 3; i++) begin
      vecs++; if ({ext_rvalid, ext_rdata, ext_ready, dm_we, dm_a} !== {1'b1, 32'h80ABCD12, 1'b0, 1'b0, 32'd0}) begin
        errs++; $display("FAIL hold_%0d got rvalid=%b rdata=%h ready=%b we=%b a=%h want 1/80abcd12/0/0/0",
                         i, ext_rvalid, ext_rdata, ext_ready, dm_we, dm_a); end
      step();
    end
    ext_rready = 1'b1; ext_valid = 1'b1; #1;
    vecs++; if (ext_ready !== 1'b0) begin errs++; $display("FAIL b2b_same_cycle got ready=%b want 0", ext_ready); end
    step(); ext_rready = 1'b0; ext_valid = 1'b0; #1;
    vecs++; if ({ext_rvalid, ext_ready, we_cnt} !== {1'b0, 1'b1, w0}) begin errs++;
      $display("FAIL hold_release got rvalid=%b ready=%b pulses=%0d want 0/1/0", ext_rvalid, ext_ready, we_cnt - w0); end
  endtask

  task automatic test_width3();
    int w0;
    logic [31:0] m0;
    w0 = we_cnt; m0 = mem[4];
    ext_issue(1'b1, 32'h10, 32'h11111111, 2'd3, 1'b0);
    step(); ext_valid = 1'b0; #1;
    vecs++; if ({ext_rvalid, ext_err, ext_rdata, dm_we} !== {1'b1, 1'b1, 32'd0, 1'b0}) begin errs++;
      $display("FAIL w3_resp got rvalid=%b err=%b rdata=%h we=%b want 1/1/0/0", ext_rvalid, ext_err, ext_rdata, dm_we); end
    ext_rready = 1'b1; step(); ext_rready = 1'b0;
    vecs++; if (we_cnt !== w0 || mem[4] !== m0) begin errs++;
      $display("FAIL w3_no_access got pulses=%0d mem=%h want 0/%h", we_cnt - w0, mem[4], m0); end
`ifdef DM_ARB_ALIGN_CHECK_EN
    w0 = we_cnt; m0 = mem[0];
    ext_issue(1'b1, 32'h2, 32'h55555555, 2'd0, 1'b0);
    step(); ext_valid = 1'b0; #1;
    vecs++; if ({ext_rvalid, ext_err} !== 2'b11) begin errs++;
      $display("FAIL mis_resp got rvalid=%b err=%b want 1/1", ext_rvalid, ext_err); end
    ext_rready = 1'b1; step(); ext_rready = 1'b0;
    vecs++; if (we_cnt !== w0 || mem[0] !== m0) begin errs++;
      $display("FAIL mis_no_access got pulses=%0d mem=%h want 0/%h", we_cnt - w0, mem[0], m0); end
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h2; cpu_wd = 32'h5; cpu_width = 2'd0; #1;
    vecs++; if ({cpu_err, dm_we} !== 2'b10) begin errs++;
      $display("FAIL cpu_mis got err=%b we=%b want 1/0", cpu_err, dm_we); end
    cpu_req = 1'b0; cpu_we = 1'b0; step();
`endif
  endtask

  task automatic test_reset_mid_pend();
    int w0;
    logic [31:0] m0;
    m0 = mem[6];
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20; cpu_width = 2'd0;
    ext_issue(1'b1, 32'h18, 32'hCAFEF00D, 2'd0, 1'b0);
    step(); ext_valid = 1'b0; step();
    w0 = we_cnt;
    reset = 1'b0; #1;
    vecs++; if ({ext_rvalid, ext_ready, dm_we, cpu_stall} !== 4'b0000) begin errs++;
      $display("FAIL rst_pend got rvalid=%b ready=%b we=%b stall=%b want 0/0/0/0", ext_rvalid, ext_ready, dm_we, cpu_stall); end
    cpu_req = 1'b0;
    step(); step();
    @(negedge clk); reset = 1'b1; step(); step();
    vecs++; if ({ext_rvalid, ext_ready} !== 2'b01 || we_cnt !== w0 || mem[6] !== m0) begin errs++;
      $display("FAIL rst_dropped got rvalid=%b ready=%b pulses=%0d mem=%h want 0/1/0/%h",
               ext_rvalid, ext_ready, we_cnt - w0, mem[6], m0); end
  endtask

  initial begin
    test_reset();
    test_ext_write();
    test_ext_read();
    test_starvation();
    test_cpu_store();
    test_byte_sign();
    test_rready_stall();
    test_width3();
    test_reset_mid_pend();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
